// File: rtl/accumulator_seq_pkg.sv
// Shared opcodes, sequencer states and the datapath control word for the
// accumulator microsequencer.
package accumulator_seq_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP = 3'd0;
  localparam logic [OP_W-1:0] OP_LDA = 3'd1;
  localparam logic [OP_W-1:0] OP_LDB = 3'd2;
  localparam logic [OP_W-1:0] OP_ADD = 3'd3;
  localparam logic [OP_W-1:0] OP_SUB = 3'd4;
  localparam logic [OP_W-1:0] OP_OUT = 3'd5;
  localparam logic [OP_W-1:0] OP_HLT = 3'd6;
  localparam logic [OP_W-1:0] OP_RSV = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EX1,
    S_EX2,
    S_HALT
  } state_e;

  typedef struct packed {
    logic bus_drv;
    logic n_la;
    logic n_lb;
    logic e_a;
    logic e_u;
    logic sub;
    logic done;
  } ctrl_t;

  // Load strobes are active-low, so "idle" is not all-zero.
  localparam ctrl_t CTRL_IDLE = '{bus_drv: 1'b0, n_la: 1'b1, n_lb: 1'b1, e_a: 1'b0,
                                  e_u: 1'b0, sub: 1'b0, done: 1'b0};

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/accumulator_seq_decode.sv
// Moore decode of (state, latched opcode) into the datapath control word.
module accumulator_seq_decode
  import accumulator_seq_pkg::*;
(
  input  state_e          state_i,
  input  logic [OP_W-1:0] op_i,
  output ctrl_t           ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    unique case (state_i)
      S_EX1: begin
        ctrl_o.done = 1'b1;
        case (op_i)
          OP_LDA: begin
            ctrl_o.bus_drv = 1'b1;
            ctrl_o.n_la    = 1'b0;
          end
          OP_LDB: begin
            ctrl_o.bus_drv = 1'b1;
            ctrl_o.n_lb    = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            // Operand goes to B first; the result lands in A during EX2.
            ctrl_o.bus_drv = 1'b1;
            ctrl_o.n_lb    = 1'b0;
            ctrl_o.done    = 1'b0;
          end
          OP_OUT:  ctrl_o.e_a = 1'b1;
          default: ;
        endcase
      end
      S_EX2: begin
        ctrl_o.e_u  = 1'b1;
        ctrl_o.sub  = (op_i == OP_SUB);
        ctrl_o.n_la = 1'b0;
        ctrl_o.done = 1'b1;
      end
      S_IDLE, S_HALT: ;
    endcase
  end

endmodule

// File: rtl/accumulator_microsequencer.sv
// Sequences one instruction at a time through fixed T-states, driving the
// accumulator/ALU datapath controls and capturing flags and the output register.
module accumulator_microsequencer
  import accumulator_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OP_W-1:0]   in_op_i,
  input  logic [DATA_W-1:0] in_operand_i,
  output logic              bus_drv_o,
  output logic [DATA_W-1:0] bus_out_o,
  input  logic [DATA_W-1:0] bus_in_i,
  output logic              n_la_o,
  output logic              n_lb_o,
  output logic              e_a_o,
  output logic              e_u_o,
  output logic              sub_o,
  input  logic              alu_cf_i,
  input  logic              alu_zf_i,
  output logic              cf_o,
  output logic              zf_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              done_o,
  output logic              halted_o,
  output logic              illegal_o
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              cf_q, cf_d;
  logic              zf_q, zf_d;
  logic              illegal_q, illegal_d;
  ctrl_t             ctrl;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    operand_d  = operand_q;
    out_data_d = out_data_q;
    cf_d       = cf_q;
    zf_d       = zf_q;
    illegal_d  = illegal_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          state_d   = S_EX1;
          op_d      = in_op_i;
          operand_d = in_operand_i;
          if (in_op_i == OP_RSV) illegal_d = 1'b1;
        end
      end
      S_EX1: begin
        if (is_alu_op(op_q)) begin
          state_d = S_EX2;
        end else if (op_q == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_IDLE;
        end
        if (op_q == OP_OUT) out_data_d = bus_in_i;
      end
      S_EX2: begin
        cf_d    = alu_cf_i;
        zf_d    = alu_zf_i;
        state_d = S_IDLE;
      end
      S_HALT: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      operand_q  <= '0;
      out_data_q <= '0;
      cf_q       <= 1'b0;
      zf_q       <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      operand_q  <= operand_d;
      out_data_q <= out_data_d;
      cf_q       <= cf_d;
      zf_q       <= zf_d;
      illegal_q  <= illegal_d;
    end
  end

  accumulator_seq_decode u_decode (
    .state_i (state_q),
    .op_i    (op_q),
    .ctrl_o  (ctrl)
  );

  assign in_ready_o = (state_q == S_IDLE);
  assign halted_o   = (state_q == S_HALT);
  assign bus_drv_o  = ctrl.bus_drv;
  assign bus_out_o  = operand_q;
  assign n_la_o     = ctrl.n_la;
  assign n_lb_o     = ctrl.n_lb;
  assign e_a_o      = ctrl.e_a;
  assign e_u_o      = ctrl.e_u;
  assign sub_o      = ctrl.sub;
  assign done_o     = ctrl.done;
  assign cf_o       = cf_q;
  assign zf_o       = zf_q;
  assign out_data_o = out_data_q;
  assign illegal_o  = illegal_q;

endmodule
